demo_gpio_ctrl: RTL and testbench

//  Bus-attached GPIO peripheral for the ibex demo system.
//  - Replaces the fixed gp_i/gp_o nets with parametrised widths.
//  - Adds a per-bit input synchroniser and debouncer, plus atomic set/clear of the outputs.
//  - Optional edge-triggered interrupts.
//  - Sits on the demo system device bus; read response one cycle after request.

---
 rtl/demo_gpio_ctrl.sv | 166 ++++++++++++++++
 tb/tb_demo_gpio_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/demo_gpio_ctrl.sv
// GPIO peripheral for the demo system device bus: synchronised, debounced inputs and
// set/clear-able outputs. Define GPIO_IRQ_EN to build the edge-triggered interrupt logic.
module demo_gpio_ctrl #(
  parameter int unsigned GpiWidth       = 8,
  parameter int unsigned GpoWidth       = 4,
  parameter int unsigned DebounceCycles = 16
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_i,
  input  logic [GpiWidth-1:0] gp_i,
  output logic [GpoWidth-1:0] gp_o,
  input  logic                device_req_i,
  input  logic                device_we_i,
  input  logic [31:0]         device_addr_i,
  input  logic [3:0]          device_be_i,
  input  logic [31:0]         device_wdata_i,
  output logic                device_rvalid_o,
  output logic [31:0]         device_rdata_o,
  output logic                irq_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);

  localparam logic [2:0] RegGpo       = 3'd0;
  localparam logic [2:0] RegGpi       = 3'd1;
  localparam logic [2:0] RegGpoSet    = 3'd2;
  localparam logic [2:0] RegGpoClr    = 3'd3;
  localparam logic [2:0] RegIrqEn     = 3'd4;
  localparam logic [2:0] RegIrqStatus = 3'd5;

  logic [GpiWidth-1:0] sync1_q, sync2_q;
  logic [GpiWidth-1:0] deb_q, deb_d;
  logic [CntW-1:0]     cnt_q [GpiWidth];
  logic [CntW-1:0]     cnt_d [GpiWidth];
  logic [GpoWidth-1:0] gpo_q, gpo_d;
  logic                rvalid_q;
  logic [31:0]         rdata_q, rdata_d;

  logic [2:0]  reg_idx;
  logic        bus_wr, bus_rd;
  logic [31:0] be_mask, gpo_ext, gpo_next;
  logic        unused_bits;

  assign reg_idx = device_addr_i[4:2];
  assign bus_wr  = device_req_i & device_we_i;
  assign bus_rd  = device_req_i & ~device_we_i;
  assign gpo_ext = 32'(gpo_q);

  assign unused_bits = ^{device_addr_i[31:5], device_addr_i[1:0], device_wdata_i, gpo_next};

  // A change is accepted only after DebounceCycles consecutive mismatching samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < int'(GpiWidth); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntW'(DebounceCycles - 1)) begin
        deb_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      be_mask[8*b +: 8] = {8{device_be_i[b]}};
    end
    gpo_next = gpo_ext;
    if (bus_wr) begin
      case (reg_idx)
        RegGpo:    gpo_next = (gpo_ext & ~be_mask) | (device_wdata_i & be_mask);
        RegGpoSet: gpo_next = gpo_ext | device_wdata_i;
        RegGpoClr: gpo_next = gpo_ext & ~device_wdata_i;
        default:   gpo_next = gpo_ext;
      endcase
    end
    gpo_d = gpo_next[GpoWidth-1:0];
  end

`ifdef GPIO_IRQ_EN
  localparam logic [15:0] PinMask = 16'((32'd1 << GpiWidth) - 32'd1);
  localparam logic [31:0] IrqMask = {PinMask, PinMask};

  logic [GpiWidth-1:0] deb_prev_q;
  logic [31:0]         irq_en_q, irq_en_d;
  logic [31:0]         status_q, status_d;
  logic [31:0]         edges, w1c;
  logic                irq_q;

  always_comb begin
    edges    = {16'(~deb_q & deb_prev_q), 16'(deb_q & ~deb_prev_q)} & irq_en_q;
    w1c      = (bus_wr && reg_idx == RegIrqStatus) ? device_wdata_i : 32'd0;
    // Set after clear so a same-cycle edge survives the W1C.
    status_d = ((status_q & ~w1c) | edges) & IrqMask;
    irq_en_d = irq_en_q;
    if (bus_wr && reg_idx == RegIrqEn) begin
      irq_en_d = device_wdata_i & IrqMask;
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      deb_prev_q <= '0;
      irq_en_q   <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      deb_prev_q <= deb_q;
      irq_en_q   <= irq_en_d;
      status_q   <= status_d;
      irq_q      <= |status_q;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rdata_d = 32'd0;
    if (bus_rd) begin
      case (reg_idx)
        RegGpo:       rdata_d = gpo_ext;
        RegGpi:       rdata_d = 32'(deb_q);
`ifdef GPIO_IRQ_EN
        RegIrqEn:     rdata_d = irq_en_q;
        RegIrqStatus: rdata_d = status_q;
`endif
        default:      rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      gpo_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      for (int i = 0; i < int'(GpiWidth); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= gp_i;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      gpo_q    <= gpo_d;
      rvalid_q <= device_req_i;
      rdata_q  <= rdata_d;
      for (int i = 0; i < int'(GpiWidth); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign gp_o            = gpo_q;
  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;

endmodule

// File: tb/tb_demo_gpio_ctrl.sv
// Directed bench for demo_gpio_ctrl at default parameters; IRQ expectations follow GPIO_IRQ_EN.
module tb_demo_gpio_ctrl;

`ifdef GPIO_IRQ_EN
  localparam bit HasIrq = 1'b1;
`else
  localparam bit HasIrq = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  gp_i = '0;
  logic [3:0]  gp_o;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        irq;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demo_gpio_ctrl #(
    .GpiWidth      (8),
    .GpoWidth      (4),
    .DebounceCycles(16)
  ) dut (
    .clk_sys_i      (clk),
    .rst_sys_i      (rst),
    .gp_i           (gp_i),
    .gp_o           (gp_o),
    .device_req_i   (req),
    .device_we_i    (we),
    .device_addr_i  (addr),
    .device_be_i    (be),
    .device_wdata_i (wdata),
    .device_rvalid_o(rvalid),
    .device_rdata_o (rdata),
    .irq_o          (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the response visible.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = '0; wdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    bus(1'b0, a, 32'd0, 4'h0);
    check({tag, " rvalid"}, 32'(rvalid), 32'd1);
    check(tag, rdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bus(1'b1, a, d, b);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset gp_o", 32'(gp_o), 32'd0);
    check("reset rvalid", 32'(rvalid), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    check("reset rdata", rdata, 32'd0);

    // Output register: byte-enabled write, set, clear.
    wr(32'h00, 32'h0000_000A, 4'h1);
    check("gpo write", 32'(gp_o), 32'hA);
    check("write rvalid", 32'(rvalid), 32'd1);
    check("write rdata", rdata, 32'd0);
    @(negedge clk);
    check("rvalid one cycle", 32'(rvalid), 32'd0);
    wr(32'h08, 32'h1, 4'hF);
    check("gpo set", 32'(gp_o), 32'hB);
    wr(32'h0C, 32'h8, 4'hF);
    check("gpo clr", 32'(gp_o), 32'h3);
    rd(32'h00, 32'h3, "read gpo");
    wr(32'h00, 32'hF, 4'h2);
    check("gpo be masked", 32'(gp_o), 32'h3);

    // 15-cycle glitch must not pass the debouncer.
    gp_i = 8'h01;
    repeat (15) @(negedge clk);
    gp_i = 8'h00;
    repeat (25) @(negedge clk);
    rd(32'h04, 32'h0, "gpi glitch");

    // Held input: GPI still 0 when sampled at cycle 17, 1 at cycle 18.
    gp_i = 8'h01;
    repeat (17) @(negedge clk);
    rd(32'h04, 32'h0, "gpi cycle17");
    rd(32'h04, 32'h1, "gpi cycle18");

    // Rise on bit1, fall on bit0.
    wr(32'h10, 32'h0001_0002, 4'hF);
    rd(32'h10, HasIrq ? 32'h0001_0002 : 32'd0, "irq_en read");
    gp_i = 8'h02;
    repeat (19) @(negedge clk);
    check("irq before", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq asserted", 32'(irq), 32'(HasIrq));
    rd(32'h14, HasIrq ? 32'h0001_0002 : 32'd0, "status edges");
    wr(32'h14, 32'h2, 4'hF);
    rd(32'h14, HasIrq ? 32'h0001_0000 : 32'd0, "status w1c");
    check("irq held", 32'(irq), 32'(HasIrq));

    // W1C of bit1 in the same cycle the new rising edge is set.
    gp_i = 8'h00;
    repeat (25) @(negedge clk);
    gp_i = 8'h02;
    repeat (18) @(negedge clk);
    wr(32'h14, 32'h2, 4'hF);
    rd(32'h14, HasIrq ? 32'h0001_0002 : 32'd0, "set beats w1c");

    wr(32'h10, 32'h0, 4'hF);
    rd(32'h14, HasIrq ? 32'h0001_0002 : 32'd0, "disable keeps status");
    wr(32'h14, 32'hFFFF_FFFF, 4'hF);
    check("irq lags clear", 32'(irq), 32'(HasIrq));
    @(negedge clk);
    check("irq cleared", 32'(irq), 32'd0);
    rd(32'h14, 32'd0, "status cleared");

    // Unmapped and read-only accesses, back to back.
    req = 1'b1; we = 1'b0; addr = 32'h18;
    @(negedge clk);
    check("b2b rd18 rvalid", 32'(rvalid), 32'd1);
    check("b2b rd18 rdata", rdata, 32'd0);
    we = 1'b1; addr = 32'h18; wdata = 32'h08; be = 4'hF;
    @(negedge clk);
    check("b2b wr18 rvalid", 32'(rvalid), 32'd1);
    check("b2b wr18 rdata", rdata, 32'd0);
    check("b2b wr18 gp_o", 32'(gp_o), 32'h3);
    addr = 32'h1C; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("b2b wr1c rvalid", 32'(rvalid), 32'd1);
    check("b2b wr1c gp_o", 32'(gp_o), 32'h3);
    addr = 32'h04; wdata = 32'hFF;
    @(negedge clk);
    we = 1'b0; addr = 32'h00;
    @(negedge clk);
    check("b2b rd gpo", rdata, 32'h3);
    addr = 32'h04;
    @(negedge clk);
    check("b2b rd gpi", rdata, 32'h2);
    check("b2b rd gpi rvalid", 32'(rvalid), 32'd1);
    req = 1'b0;
    @(negedge clk);
    check("b2b idle rvalid", 32'(rvalid), 32'd0);

    // Asynchronous reset mid-transaction.
    wr(32'h08, 32'hC, 4'hF);
    check("gpo set all", 32'(gp_o), 32'hF);
    req = 1'b1; we = 1'b0; addr = 32'h00;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset gp_o", 32'(gp_o), 32'd0);
    check("midreset rvalid", 32'(rvalid), 32'd0);
    check("midreset irq", 32'(irq), 32'd0);
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(32'h04, 32'h0, "gpi after reset");
    repeat (20) @(negedge clk);
    rd(32'h04, 32'h2, "gpi requalified");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
